// File: rtl/gbuf_port_arbiter_if.sv
// Port bundle for the global-buffer arbiter: three requesters on one side,
// the single-port global buffer on the other.
interface gbuf_port_arbiter_if #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 512,
    parameter int LEN_W  = 5
);
    // requester side
    logic [2:0]          req;
    logic [2:0]          we;
    logic [3*ADDR_W-1:0] addr;
    logic [3*LEN_W-1:0]  len;
    logic [3*DATA_W-1:0] wdata;
    logic [2:0]          gnt;
    logic [2:0]          beat;
    logic [2:0]          rvalid;
    logic [DATA_W-1:0]   rdata;
    logic                busy;
    // buffer side
    logic                mem_en;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W-1:0]   mem_rdata;

    // Environment view: requesters plus the buffer model.
    modport master (
        output req, we, addr, len, wdata, mem_rdata,
        input  gnt, beat, rvalid, rdata, busy, mem_en, mem_we, mem_addr, mem_wdata
    );

    // Arbiter view.
    modport slave (
        input  req, we, addr, len, wdata, mem_rdata,
        output gnt, beat, rvalid, rdata, busy, mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/gbuf_port_arbiter.sv
// Burst-granular round-robin arbiter sharing the single-port global buffer
// between the input loader (0), PFT fetch (1) and aggregation writeback (2).
// Read data is returned to the burst owner through a tagged valid pipeline
// matched to the buffer read latency.
module gbuf_port_arbiter #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 512,
    parameter int LEN_W  = 5,
    parameter int RD_LAT = 2
) (
    input logic                clk,
    input logic                rst,
    gbuf_port_arbiter_if.slave bus
);
    localparam int DRAIN_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;

    state_t              state_reg, state_next;
    logic [1:0]          owner_reg, owner_next;
    logic [1:0]          rr_reg, rr_next;       // last winner
    logic                we_reg, we_next;
    logic [ADDR_W-1:0]   addr_reg, addr_next;   // address of the current beat
    logic [LEN_W-1:0]    len_reg, len_next;     // effective length, never 0
    logic [LEN_W-1:0]    cnt_reg, cnt_next;     // beat index within the burst
    logic [DRAIN_W-1:0]  drain_reg, drain_next;

    logic [ADDR_W-1:0]   addr_arr  [3];
    logic [LEN_W-1:0]    len_arr   [3];
    logic [DATA_W-1:0]   wdata_arr [3];

    logic                win_valid;
    logic [1:0]          win;

    logic [2:0]          gnt_c;
    logic [2:0]          beat_c;
    logic                mem_en_c;
    logic                mem_we_c;
    logic [ADDR_W-1:0]   mem_addr_c;

    logic                rv_valid [RD_LAT];
    logic [1:0]          rv_owner [RD_LAT];

    // Unpack the flat per-requester buses into indexable arrays.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_unpack
            assign addr_arr[gi]  = bus.addr[gi*ADDR_W +: ADDR_W];
            assign len_arr[gi]   = bus.len[gi*LEN_W +: LEN_W];
            assign wdata_arr[gi] = bus.wdata[gi*DATA_W +: DATA_W];
        end
    endgenerate

    function automatic logic [1:0] rr_step(input logic [1:0] i);
        return (i == 2'd2) ? 2'd0 : i + 2'd1;
    endfunction

    // Round-robin pick: search starts one past the last winner.
    always_comb begin
        logic [1:0] cand;
        cand      = rr_reg;
        win_valid = 1'b0;
        win       = 2'd0;
        for (int k = 0; k < 3; k++) begin
            cand = rr_step(cand);
            if (!win_valid && bus.req[cand]) begin
                win_valid = 1'b1;
                win       = cand;
            end
        end
    end

    // State and burst context registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            owner_reg <= 2'd0;
            rr_reg    <= 2'd2;
            we_reg    <= 1'b0;
            addr_reg  <= '0;
            len_reg   <= LEN_W'(1);
            cnt_reg   <= '0;
            drain_reg <= '0;
        end else begin
            state_reg <= state_next;
            owner_reg <= owner_next;
            rr_reg    <= rr_next;
            we_reg    <= we_next;
            addr_reg  <= addr_next;
            len_reg   <= len_next;
            cnt_reg   <= cnt_next;
            drain_reg <= drain_next;
        end
    end

    // Next-state and buffer/strobe outputs.
    always_comb begin
        state_next = state_reg;
        owner_next = owner_reg;
        rr_next    = rr_reg;
        we_next    = we_reg;
        addr_next  = addr_reg;
        len_next   = len_reg;
        cnt_next   = cnt_reg;
        drain_next = drain_reg;
        gnt_c      = 3'b000;
        beat_c     = 3'b000;
        mem_en_c   = 1'b0;
        mem_we_c   = 1'b0;
        mem_addr_c = '0;

        case (state_reg)
            IDLE: begin
                if (win_valid) begin
                    owner_next = win;
                    rr_next    = win;
                    we_next    = bus.we[win];
                    addr_next  = addr_arr[win];
                    len_next   = (len_arr[win] == '0) ? LEN_W'(1) : len_arr[win];
                    cnt_next   = '0;
                    state_next = BURST;
                end
            end
            BURST: begin
                mem_en_c          = 1'b1;
                mem_we_c          = we_reg;
                mem_addr_c        = addr_reg;
                beat_c[owner_reg] = 1'b1;
                gnt_c[owner_reg]  = (cnt_reg == '0);
                addr_next         = addr_reg + ADDR_W'(1);   // wraps naturally
                cnt_next          = cnt_reg + LEN_W'(1);
                drain_next        = '0;
                if (cnt_reg == len_reg - LEN_W'(1)) begin
                    state_next = we_reg ? IDLE : DRAIN;
                end
            end
            DRAIN: begin
                // Keep the port idle until the last read word has returned.
                drain_next = drain_reg + DRAIN_W'(1);
                if (drain_reg == DRAIN_W'(RD_LAT - 1)) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Read-return pipeline head: tag each read access with its owner.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rv_valid[0] <= 1'b0;
            rv_owner[0] <= 2'd0;
        end else begin
            rv_valid[0] <= mem_en_c & ~mem_we_c;
            rv_owner[0] <= owner_reg;
        end
    end

    generate
        for (genvar gi = 1; gi < RD_LAT; gi++) begin : g_rv_pipe
            // Shift the tag along so it lines up with mem_rdata.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rv_valid[gi] <= 1'b0;
                    rv_owner[gi] <= 2'd0;
                end else begin
                    rv_valid[gi] <= rv_valid[gi-1];
                    rv_owner[gi] <= rv_owner[gi-1];
                end
            end
        end
    endgenerate

    assign bus.gnt       = gnt_c;
    assign bus.beat      = beat_c;
    assign bus.busy      = (state_reg != IDLE);
    assign bus.mem_en    = mem_en_c;
    assign bus.mem_we    = mem_we_c;
    assign bus.mem_addr  = mem_addr_c;
    assign bus.mem_wdata = wdata_arr[owner_reg];
    assign bus.rdata     = bus.mem_rdata;
    assign bus.rvalid    = rv_valid[RD_LAT-1] ? (3'b001 << rv_owner[RD_LAT-1]) : 3'b000;

endmodule
